bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Round-robin arbiter and multiplexer for the shared address/data bus. Masters include the execution state machine, a memory loader/DMA and the test harness. The block grants exactly one master at a time and drives that master's address, nRead, nWrite and data onto the shared bus. It decodes address[15:12] into the one-hot slave-enable vector consumed by main memory, the register file, instruction memory, the matrix ALU, the integer ALU and the execute port. It sits between the masters and every bus slave.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
ADDR_W, 16, bus address width; [15:12] is the slave select
DATA_W, 256, bus data width
NUM_SLAVES, 6, slave select codes 0..NUM_SLAVES-1 are valid
MAX_HOLD, 64, maximum consecutive owned cycles (timeout feature only)

Ports:
Clk  input  1  bus clock, rising edge
nReset  input  1  asynchronous active-low reset
Req  input  NUM_MASTERS  per-master bus request, level, held for whole transfer
Gnt  output  NUM_MASTERS  registered one-hot grant
MAddr  input  NUM_MASTERS x ADDR_W  per-master address
MnRead  input  NUM_MASTERS  per-master active-low read strobe
MnWrite  input  NUM_MASTERS  per-master active-low write strobe
MData  input  NUM_MASTERS x DATA_W  per-master write data
BusAddr  output  ADDR_W  shared address
BusnRead  output  1  shared active-low read
BusnWrite  output  1  shared active-low write
BusData  output  DATA_W  shared write data
SlaveEn  output  NUM_SLAVES  one-hot slave enable
DecodeErr  output  1  owner drives select >= NUM_SLAVES
Timeout  output  1  one-cycle forced-release pulse

Behaviour:
- Reset, asynchronous: state = IDLE, Gnt = 0, rr pointer = 0, hold counter = 0, Timeout = 0.
- States:
  - IDLE: no owner.
  - OWNED: Gnt one-hot.
  - TURN: one-cycle bus turnaround, Gnt = 0.
- IDLE with any Req at posedge -> OWNED. The winner is the first requester found scanning from the rr pointer upward, wrapping modulo NUM_MASTERS. Gnt is valid in the following cycle, so latency is 1 cycle.
- OWNED stays while Req[owner] = 1. Req[owner] = 0 at posedge -> TURN, Gnt cleared, pointer = (owner+1) mod NUM_MASTERS.
- TURN always -> IDLE-style arbitration at the next posedge. If requests are pending, it goes directly to OWNED, so back-to-back owners are separated by exactly one idle cycle.
- Bus drive is combinational from the registered owner.
  - In OWNED: BusAddr/BusnRead/BusnWrite/BusData = the owner's signals.
  - Otherwise: BusAddr = 0, BusnRead = 1, BusnWrite = 1, BusData = 0.
- SlaveEn: in OWNED with BusAddr[15:12] < NUM_SLAVES, bit BusAddr[15:12] = 1; otherwise all 0. No enable is ever driven in IDLE or TURN.
- DecodeErr = 1 in OWNED when BusAddr[15:12] >= NUM_SLAVES. SlaveEn = 0 in that case. This is combinational.
- Non-owner inputs are ignored entirely.
- Simultaneous requests are resolved by pointer order only. A master that just released is lowest priority.
- Req of a non-owner rising while OWNED is held pending. No preemption.
- Owner nRead = nWrite = 0 simultaneously is passed through unchanged; the slaves define the behaviour.
- nReset mid-transfer drops Gnt and returns the bus to idle values immediately, asynchronously through the state clear.

Optional Feature:
Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - The hold counter increments each OWNED cycle and clears on entry to OWNED.
  - When the counter reaches MAX_HOLD-1 with Req[owner] still 1, the next posedge forces TURN and advances the pointer past the owner.
  - Timeout = 1 for that TURN cycle only.
  - The evicted master competes again from lowest priority.
- Not defined: no counter, Timeout tied 0, and ownership is unbounded.

Decomposition:
- Package bus_pkg holds:
  - slave select constants MainMemEn=0, RegisterEn=1, InstrMemEn=2, MatrixAluEn=3, IntegerAluEn=4, ExecuteEn=5;
  - the arbiter state enum {IDLE, OWNED, TURN};
  - ADDR_W/DATA_W defaults.
- Sub-module rr_picker: a combinational round-robin pick from (Req, pointer) that returns a one-hot winner plus an any-valid flag.

Test Plan:
- Reset, then Req=01 with MAddr[0]=16'h2000 and MnRead[0]=0 → Gnt=01 one cycle later, SlaveEn=000100, BusnRead=0, BusAddr=16'h2000.
- Req=11 from IDLE with pointer 0 → master 0 owns. Drop Req[0] → one TURN cycle with bus idle and SlaveEn=0, then Gnt=10.
- Fairness: hold Req=11 and each owner releases after 3 cycles → grants alternate 01,10,01,10 with one TURN cycle between each.
- Master 1 owns with BusAddr=16'h7000 → DecodeErr=1, SlaveEn=0. With 16'h3004 → SlaveEn=001000, DecodeErr=0.
- Assert nReset=0 asynchronously mid-OWNED (between edges) → Gnt=0, BusnRead=BusnWrite=1, BusAddr=0 immediately. After release, Req=10 wins first because the pointer was reset to 0 and Req[0]=0.
- With BUS_ARB_TIMEOUT_EN and MAX_HOLD=4, hold Req=11 and master 0 never releases → after 4 OWNED cycles Timeout pulses 1 cycle, then Gnt=10.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, slave select codes and the arbiter state type.
package bus_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 256;
  localparam logic [3:0] MainMemEn    = 4'd0;
  localparam logic [3:0] RegisterEn   = 4'd1;
  localparam logic [3:0] InstrMemEn   = 4'd2;
  localparam logic [3:0] MatrixAluEn  = 4'd3;
  localparam logic [3:0] IntegerAluEn = 4'd4;
  localparam logic [3:0] ExecuteEn    = 4'd5;
  typedef enum logic [1:0] {IDLE, OWNED, TURN} arb_state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: per-master request/transfer signals and the shared bus outputs.
interface bus_arbiter_if import bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int NUM_SLAVES = 6
);
  logic [NUM_MASTERS-1:0] Req;
  logic [NUM_MASTERS-1:0] Gnt;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] MAddr;
  logic [NUM_MASTERS-1:0] MnRead;
  logic [NUM_MASTERS-1:0] MnWrite;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] MData;
  logic [ADDR_W-1:0] BusAddr;
  logic BusnRead;
  logic BusnWrite;
  logic [DATA_W-1:0] BusData;
  logic [NUM_SLAVES-1:0] SlaveEn;
  logic DecodeErr;
  logic Timeout;
  modport master (
    output Req, MAddr, MnRead, MnWrite, MData,
    input Gnt, BusAddr, BusnRead, BusnWrite, BusData, SlaveEn, DecodeErr, Timeout
  );
  modport slave (
    input Req, MAddr, MnRead, MnWrite, MData,
    output Gnt, BusAddr, BusnRead, BusnWrite, BusData, SlaveEn, DecodeErr, Timeout
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first requester at or above ptr, wrapping.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  // Scan from the far end back toward ptr so the closest requester is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with owner mux and slave select decode.
// Define BUS_ARB_TIMEOUT_EN to evict an owner after MAX_HOLD consecutive cycles.
module bus_arbiter import bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int NUM_SLAVES = 6,
  parameter int MAX_HOLD = 64
) (
  input logic Clk,
  input logic nReset,
  bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, pick_idx;
  logic [NUM_MASTERS-1:0] gnt, gnt_n, pick_gnt;
  logic pick_any, own, expire, tmo, tmo_n;
  logic [3:0] sel;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || ADDR_W < 4 || DATA_W < 1 ||
      NUM_SLAVES < 1 || NUM_SLAVES > 16 || MAX_HOLD < 2) begin : g_bad_params
    $error("bus_arbiter: parameter out of range");
  end

  rr_picker #(.N(NUM_MASTERS), .W(IW)) u_pick (
    .req(bus.Req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold;
  assign expire = hold == HW'(MAX_HOLD - 1);
  // Zero outside OWNED, so every new ownership starts counting from zero.
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) hold <= '0;
    else hold <= (state == OWNED) ? hold + 1'b1 : '0;
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    gnt_n = gnt;
    tmo_n = 1'b0;
    if (state == OWNED) begin
      if (!bus.Req[owner] || expire) begin
        state_n = TURN;
        gnt_n = '0;
        ptr_n = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
        tmo_n = bus.Req[owner];
      end
    end else begin
      state_n = pick_any ? OWNED : IDLE;
      owner_n = pick_any ? pick_idx : owner;
      gnt_n = pick_gnt;
    end
  end

  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      gnt <= '0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      tmo <= tmo_n;
    end

  assign own = state == OWNED;
  assign bus.Gnt = gnt;
  assign bus.Timeout = tmo;
  assign bus.BusAddr = own ? bus.MAddr[owner] : '0;
  assign bus.BusnRead = own ? bus.MnRead[owner] : 1'b1;
  assign bus.BusnWrite = own ? bus.MnWrite[owner] : 1'b1;
  assign bus.BusData = own ? bus.MData[owner] : '0;
  assign sel = bus.BusAddr[ADDR_W-1 -: 4];
  assign bus.DecodeErr = own && (int'(sel) >= NUM_SLAVES);
  assign bus.SlaveEn = (own && !bus.DecodeErr) ? NUM_SLAVES'(1) << sel : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus randomized stimulus, scoreboard checked against a
// behavioural model of ownership, fairness, decode, async reset and timeout.
module tb_bus_arbiter;
  import bus_pkg::*;
  localparam int N = 2;
  localparam int AW = 16;
  localparam int DW = 256;
  localparam int NS = 6;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int MH = 4;
  localparam bit TMO = 1'b1;
`else
  localparam int MH = 64;
  localparam bit TMO = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [AW-1:0] addr;
    logic nrd;
    logic nwr;
    logic [DW-1:0] data;
    logic [NS-1:0] en;
    logic err;
    logic tmo;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [N-1:0] req_v, nrd_v, nwr_v;
  logic [AW-1:0] addr_v [N];
  logic [DW-1:0] data_v [N];

  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  bit m_tmo = 1'b0;
  bit m_rst = 1'b1;

  bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus();

  bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .MAX_HOLD(MH)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  function automatic bit bit_of(logic [N-1:0] v, int j);
    return ((v >> j) & 1) != 0;
  endfunction

  // Ownership rules at a clock edge, using the requests present at that edge.
  task automatic model_step();
    logic [N-1:0] r;
    r = bus.Req;
    m_tmo = 1'b0;
    if (m_rst) return;
    if (m_owner >= 0) begin
      if (!bit_of(r, m_owner) || (TMO && m_held == MH)) begin
        m_tmo = bit_of(r, m_owner);
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else m_held++;
    end else begin
      for (int k = 0; k < N; k++)
        if (bit_of(r, (m_ptr + k) % N)) begin
          m_owner = (m_ptr + k) % N;
          m_held = 1;
          break;
        end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t x;
    int s;
    x = '0;
    x.nrd = 1'b1;
    x.nwr = 1'b1;
    x.tmo = m_tmo;
    if (m_owner >= 0) begin
      x.gnt = N'(1) << m_owner;
      x.addr = addr_v[m_owner];
      x.nrd = bit_of(nrd_v, m_owner);
      x.nwr = bit_of(nwr_v, m_owner);
      x.data = data_v[m_owner];
      s = int'(x.addr[AW-1 -: 4]);
      if (s < NS) x.en = NS'(1) << s;
      else x.err = 1'b1;
    end
    return x;
  endfunction

  // One cycle: advance the model at the edge, apply new inputs, queue the expectation.
  task automatic tick(input bit do_rst, input bit do_rel);
    @(posedge Clk);
    #1;
    model_step();
    if (do_rel) begin
      nReset = 1'b1;
      m_rst = 1'b0;
    end
    bus.Req = req_v;
    bus.MnRead = nrd_v;
    bus.MnWrite = nwr_v;
    for (int i = 0; i < N; i++) begin
      bus.MAddr[i] = addr_v[i];
      bus.MData[i] = data_v[i];
    end
    if (do_rst) begin
      #2;
      nReset = 1'b0;
      m_rst = 1'b1;
      m_owner = -1;
      m_ptr = 0;
      m_held = 0;
      m_tmo = 1'b0;
    end
    q.push_back(expect_now());
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("Gnt", DW'(bus.Gnt), DW'(e.gnt));
      chk("BusAddr", DW'(bus.BusAddr), DW'(e.addr));
      chk("BusnRead", DW'(bus.BusnRead), DW'(e.nrd));
      chk("BusnWrite", DW'(bus.BusnWrite), DW'(e.nwr));
      chk("BusData", bus.BusData, e.data);
      chk("SlaveEn", DW'(bus.SlaveEn), DW'(e.en));
      chk("DecodeErr", DW'(bus.DecodeErr), DW'(e.err));
      chk("Timeout", DW'(bus.Timeout), DW'(e.tmo));
    end

  initial begin
    req_v = '0;
    nrd_v = '1;
    nwr_v = '1;
    for (int i = 0; i < N; i++) begin
      addr_v[i] = '0;
      data_v[i] = '0;
    end
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    // Both request from reset: master 0 reads instruction memory first.
    addr_v[0] = 16'h2000;
    nrd_v = 2'b10;
    data_v[0] = {8{32'hA5A5_0001}};
    addr_v[1] = 16'h1010;
    nwr_v = 2'b01;
    data_v[1] = {8{32'h5A5A_0002}};
    req_v = 2'b11;
    repeat (4) tick(1'b0, 1'b0);
    req_v = 2'b10;
    repeat (4) tick(1'b0, 1'b0);
    req_v = 2'b00;
    repeat (2) tick(1'b0, 1'b0);
    // Fairness: both keep requesting, each owner lets go after 3 cycles.
    for (int c = 0; c < 24; c++) begin
      req_v = 2'b11;
      if (m_owner >= 0 && m_held >= 3) req_v = req_v & ~(N'(1) << m_owner);
      tick(1'b0, 1'b0);
    end
    req_v = 2'b00;
    repeat (2) tick(1'b0, 1'b0);
    // Decode: unmapped select, then matrix ALU, then async reset mid-ownership.
    addr_v[1] = 16'h7000;
    req_v = 2'b10;
    repeat (4) tick(1'b0, 1'b0);
    addr_v[1] = 16'h3004;
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    req_v = 2'b00;
    repeat (2) tick(1'b0, 1'b0);
    // Master 0 never lets go; with the timeout enabled it is evicted.
    addr_v[0] = 16'h0040;
    req_v = 2'b11;
    repeat (14) tick(1'b0, 1'b0);
    req_v = 2'b00;
    repeat (2) tick(1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_v[i]) begin
          if ($urandom_range(0, 5) == 0) req_v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) req_v[i] = 1'b1;
        addr_v[i] = {4'($urandom_range(0, 8)), 12'($urandom)};
        nrd_v[i] = 1'($urandom);
        nwr_v[i] = 1'($urandom);
        data_v[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (m_rst) tick(1'b0, 1'b1);
      else tick($urandom_range(0, 299) == 0, 1'b0);
    end
    req_v = 2'b00;
    repeat (2) tick(1'b0, 1'b0);
    @(negedge Clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
